// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus iterative shift-add multiply.
// Optional restoring divider (DIVU/REMU) enabled by defining MULTICYCLE_ALU_DIV_EN.
module multicycle_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_in_1,
  input  logic [WIDTH-1:0] alu_in_2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [2:0]       alu_bcond,
  output logic             illegal,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
`ifdef MULTICYCLE_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q;
  logic               in_ready_q, out_valid_q, busy_q, illegal_q;
  logic [WIDTH-1:0]   result_q;
  logic [2:0]         bcond_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   opnd_q;    // multiplicand for MUL, divisor for DIV
  logic [2*WIDTH-1:0] prod_q;    // product, or {remainder, quotient/dividend}
  logic               hi_sel_q;  // result from upper half (MULHU/REMU)
  logic               div_q;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ill;
  logic               is_multi;
  logic               acc_div;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   final_res;

  function automatic logic [2:0] flags(input logic [WIDTH-1:0] r);
    return {(~r[WIDTH-1]) & (r != '0), r[WIDTH-1], (r == '0)};
  endfunction

  // Single-cycle result and dispatch decode
  always_comb begin
    sc_res   = '0;
    sc_ill   = 1'b0;
    is_multi = 1'b0;
    acc_div  = 1'b0;
    shamt    = alu_in_2[SHAMT_W-1:0];
    case (alu_control)
      OP_AND:   sc_res = alu_in_1 & alu_in_2;
      OP_OR:    sc_res = alu_in_1 | alu_in_2;
      OP_ADD:   sc_res = alu_in_1 + alu_in_2;
      OP_SUB:   sc_res = alu_in_1 - alu_in_2;
      OP_XOR:   sc_res = alu_in_1 ^ alu_in_2;
      OP_SLL:   sc_res = alu_in_1 << shamt;
      OP_SRL:   sc_res = alu_in_1 >> shamt;
      OP_SRA:   sc_res = WIDTH'($signed(alu_in_1) >>> shamt);
      OP_MUL,
      OP_MULHU: is_multi = 1'b1;
`ifdef MULTICYCLE_ALU_DIV_EN
      OP_DIVU: begin
        if (alu_in_2 == '0) sc_res = '1;
        else begin
          is_multi = 1'b1;
          acc_div  = 1'b1;
        end
      end
      OP_REMU: begin
        if (alu_in_2 == '0) sc_res = alu_in_1;
        else begin
          is_multi = 1'b1;
          acc_div  = 1'b1;
        end
      end
`endif
      default:  sc_ill = 1'b1;
    endcase
  end

  // One iteration of shift-add multiply, or restoring divide when enabled
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    step_next = mul_next;
`ifdef MULTICYCLE_ALU_DIV_EN
    begin : div_step
      logic [WIDTH:0] trial;
      logic [WIDTH:0] diff;
      logic           ge;
      trial = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
      diff  = trial - {1'b0, opnd_q};
      ge    = (trial >= {1'b0, opnd_q});
      if (div_q) begin
        step_next = {(ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), prod_q[WIDTH-2:0], ge};
      end
    end
`endif
    final_res = hi_sel_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      illegal_q   <= 1'b0;
      result_q    <= '0;
      bcond_q     <= 3'b001;
      cnt_q       <= '0;
      opnd_q      <= '0;
      prod_q      <= '0;
      hi_sel_q    <= 1'b0;
      div_q       <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (is_multi) begin
              state_q  <= S_BUSY;
              busy_q   <= 1'b1;
              cnt_q    <= CNT_W'(WIDTH);
              opnd_q   <= acc_div ? alu_in_2 : alu_in_1;
              prod_q   <= {{WIDTH{1'b0}}, (acc_div ? alu_in_1 : alu_in_2)};
              hi_sel_q <= alu_control[0];
              div_q    <= acc_div;
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= sc_res;
              bcond_q     <= flags(sc_res);
              illegal_q   <= sc_ill;
            end
          end
        end
        S_BUSY: begin
          prod_q <= step_next;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            result_q    <= final_res;
            bcond_q     <= flags(final_res);
            illegal_q   <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign illegal    = illegal_q;
  assign alu_result = result_q;
  assign alu_bcond  = bcond_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu (WIDTH=32); divider cases follow MULTICYCLE_ALU_DIV_EN.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, illegal, busy;
  logic [31:0] alu_in_1, alu_in_2, alu_result;
  logic [3:0]  alu_control;
  logic [2:0]  alu_bcond;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .alu_bcond(alu_bcond),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure latency/busy cycles, check result, optionally hold, then release
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input logic [2:0] exp_bc, input logic exp_ill, input int hold);
    int lat;
    int busy_n;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    alu_control = op; alu_in_1 = a; alu_in_2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; alu_in_1 = $urandom; alu_in_2 = $urandom; alu_control = 4'hF;
    lat = 1; busy_n = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    check({tag, ".result"}, 64'(alu_result), 64'(exp_res));
    check({tag, ".bcond"}, 64'(alu_bcond), 64'(exp_bc));
    check({tag, ".illegal"}, 64'(illegal), 64'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_result"}, 64'(alu_result), 64'(exp_res));
      check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, ".hold_out_valid"}, 64'(out_valid), 64'd1);
    end
    // Offer a new op during the release edge; it must not be taken
    out_ready = 1'b1; in_valid = 1'b1; alu_control = 4'b0010;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    check({tag, ".release_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".release_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check({tag, ".never_valid"}, 64'(seen), 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_in_1 = '0; alu_in_2 = '0; alu_control = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.illegal", 64'(illegal), 64'd0);
    check("rst.result", 64'(alu_result), 64'd0);
    check("rst.bcond", 64'(alu_bcond), 64'd1);

    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 3'b010, 1'b0, 0);
    run_op("and",     4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1, 32'h00F0_000F, 3'b100, 1'b0, 0);
    run_op("or",      4'b0001, 32'h0000_1200, 32'h0000_0034, 1, 32'h0000_1234, 3'b100, 1'b0, 0);
    run_op("xor",     4'b0111, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 32'hF0F0_0F0F, 3'b010, 1'b0, 0);
    run_op("sub_neg", 4'b0110, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 3'b010, 1'b0, 0);
    run_op("sll",     4'b0011, 32'h1, 32'h21, 1, 32'h2, 3'b100, 1'b0, 0);
    run_op("srl",     4'b1000, 32'h8000_0000, 32'h1F, 1, 32'h1, 3'b100, 1'b0, 0);
    run_op("sra_hold",4'b1001, 32'h8000_0000, 32'h24, 1, 32'hF800_0000, 3'b010, 1'b0, 5);
    run_op("mul",     4'b1010, 32'd3, 32'd5, 33, 32'd15, 3'b100, 1'b0, 0);
    run_op("mul_wrap",4'b1010, 32'h0001_0000, 32'h0001_0000, 33, 32'h0, 3'b001, 1'b0, 0);
    run_op("mulhu",   4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 3'b010, 1'b0, 0);
    run_op("ill_f",   4'b1111, 32'd7, 32'd9, 1, 32'h0, 3'b001, 1'b1, 0);
`ifdef MULTICYCLE_ALU_DIV_EN
    run_op("divu",    4'b1100, 32'd100, 32'd7, 33, 32'd14, 3'b100, 1'b0, 0);
    run_op("remu",    4'b1101, 32'd100, 32'd7, 33, 32'd2, 3'b100, 1'b0, 0);
    run_op("divu_z",  4'b1100, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 3'b010, 1'b0, 0);
    run_op("remu_z",  4'b1101, 32'd5, 32'd0, 1, 32'd5, 3'b100, 1'b0, 0);
`else
    run_op("divu_ill",4'b1100, 32'd100, 32'd7, 1, 32'h0, 3'b001, 1'b1, 0);
    run_op("remu_ill",4'b1101, 32'd100, 32'd7, 1, 32'h0, 3'b001, 1'b1, 0);
`endif

    // Flush on the 10th BUSY cycle of MUL 3*5
    alu_control = 4'b1010; alu_in_1 = 32'd3; alu_in_2 = 32'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("flush.busy_started", 64'(busy), 64'd1);
    for (int i = 0; i < 9; i++) tick();
    check("flush.busy_10th", 64'(busy), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("flush.in_ready", 64'(in_ready), 64'd1);
    check("flush.busy", 64'(busy), 64'd0);
    watch_no_valid("flush", 40);
    run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 1, 32'h0, 3'b001, 1'b0, 0);

    // Flush beats in_valid in IDLE
    alu_control = 4'b0010; alu_in_1 = 32'd1; alu_in_2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle.in_ready", 64'(in_ready), 64'd1);
    watch_no_valid("flush_idle", 3);

    // Reset mid-multiply abandons the operation
    alu_control = 4'b1011; alu_in_1 = 32'hFFFF_FFFF; alu_in_2 = 32'h2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.result", 64'(alu_result), 64'd0);
    check("midrst.bcond", 64'(alu_bcond), 64'd1);
    watch_no_valid("midrst", 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
